zjh_cmp_pipe: RTL and testbench
===============================

Name: zjh_cmp_pipe

Overview:
- Parametrised, pipelined magnitude comparator with a valid/ready stream interface.
- Per transaction it takes two WIDTH-bit operands and optionally converts them from Gray code to binary.
- It compares the operands as unsigned or signed values and outputs registered one-hot AEB/AGB/ALB flags.
- It keeps saturating event counters for each flag.
- It sits between the operand-conversion stage and downstream control logic. It replaces the ad-hoc combinational comparator trio.

Parameters:
- WIDTH, 8, operand width in bits (2..32).
- GRAY_IN, 0, 1 = operands arrive Gray-coded and are converted to binary in stage 1; 0 = pass through.
- CNT_WIDTH, 16, width of each event counter.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- DataA  input  WIDTH  operand A.
- DataB  input  WIDTH  operand B.
- SignedMode  input  1  1 = two's-complement compare; 0 = unsigned. Sampled with the operands.
- InValid  input  1  operands and SignedMode are valid.
- InReady  output  1  block can accept operands this cycle.
- AEB  output  1  A == B.
- AGB  output  1  A > B.
- ALB  output  1  A < B.
- OutValid  output  1  AEB/AGB/ALB are valid.
- OutReady  input  1  downstream accepts the result.
- CntClr  input  1  synchronous clear of all counters.
- CntEQ  output  CNT_WIDTH  number of accepted results with AEB = 1.
- CntGT  output  CNT_WIDTH  number of accepted results with AGB = 1.
- CntLT  output  CNT_WIDTH  number of accepted results with ALB = 1.

Behaviour:
- Reset (asynchronous, RST = 1):
  - Stage-1 and stage-2 valid bits are 0, so OutValid = 0.
  - AEB, AGB, ALB = 0.
  - CntEQ, CntGT, CntLT = 0.
  - Stage data registers = 0.
  - InReady = 1 from the first cycle after RST deasserts.
- Reset mid-operation discards all in-flight transactions; no partial result is emitted.
- Input handshake: a transaction is accepted on a rising edge where InValid && InReady.
- Pipeline structure:
  - Stage 1 registers the converted operands and SignedMode.
  - Stage 2 registers the compare flags.
- Advance rules:
  - s2_adv = !OutValid || OutReady.
  - s1_adv = !s1_valid || s2_adv.
  - InReady = s1_adv, which is combinational from OutReady.
- A full pipeline with OutReady = 1 accepts one transaction per cycle.
- Latency: OutValid rises 2 cycles after acceptance when there is no backpressure.
- Bubbles collapse: a stalled stage 2 does not block stage 1 if stage 1 is empty.
- Gray conversion (GRAY_IN = 1), per operand:
  - bin[WIDTH-1] = g[WIDTH-1].
  - bin[i] = bin[i+1] ^ g[i].
  - The conversion is combinational before the stage-1 register.
- Comparison is done in stage 2 on the converted values.
  - SignedMode = 0: unsigned compare.
  - SignedMode = 1: MSB is the sign bit, two's-complement ordering.
  - SignedMode travels with its own transaction; changing the input between transactions never affects data in flight.
- When OutValid = 1, exactly one of AEB/AGB/ALB is 1.
- When OutValid = 0, the flags hold their last value. Verification checks flags only when OutValid = 1.
- Output stability: while OutValid && !OutReady, AEB/AGB/ALB and OutValid stay constant.
- Once OutValid is 1, it does not drop without an output handshake (OutValid && OutReady).
- Counters:
  - On each output handshake, increment the counter matching the asserted flag by 1.
  - Counters saturate at 2^CNT_WIDTH-1 and never wrap.
  - CntClr = 1 sets all counters to 0 on that edge.
  - If CntClr and a handshake occur in the same cycle, clear wins and that result is not counted.
  - Counters are unaffected by transactions still in flight.
- Simultaneous events:
  - An input accept and an output handshake in the same cycle are both honoured; the pipeline shifts.
  - InValid is ignored while InReady = 0. The upstream must hold its data.

Test Plan:
1. Reset then single transaction: WIDTH = 8, GRAY_IN = 0, SignedMode = 0, A = 0x80, B = 0x7F, OutReady = 1 -> 2 cycles later OutValid = 1, AGB = 1, AEB = ALB = 0; CntGT = 1 one cycle after the handshake.
2. Signed mode: same operands with SignedMode = 1 -> ALB = 1; equal case A = B = 0xFF -> AEB = 1, CntEQ increments.
3. Gray input (GRAY_IN = 1): A = 8'b00000011 (binary 2), B = 8'b00000010 (binary 3) -> ALB = 1.
4. Backpressure with back-to-back stream:
   - Stimulus: stream 4 transactions with InValid = 1; hold OutReady = 0 for 3 cycles.
   - InReady falls to 0 after 2 transactions are accepted.
   - Flags stay stable while stalled.
   - After OutReady = 1, all 4 results arrive in order with no loss or duplication.
5. Counters:
   - Force CntLT to saturate using CNT_WIDTH = 2 and 5 LT results -> CntLT = 3.
   - Assert CntClr together with a handshake -> all counters = 0.
6. Asynchronous RST pulse mid-stream with 2 transactions in flight -> OutValid = 0 immediately, no stale result after release, counters = 0, InReady = 1.

Source files
------------

// File: rtl/zjh_cmp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : zjh_cmp_pipe
// Purpose  : Two-stage pipelined magnitude comparator with a valid/ready
//            stream interface. Operands may optionally arrive Gray-coded and
//            are converted to binary before stage 1. Stage 2 holds one-hot
//            AEB/AGB/ALB flags. Saturating counters tally accepted results.
// Ports    : CLK, RST          - clock, asynchronous active-high reset
//            DataA, DataB      - WIDTH-bit operands
//            SignedMode        - 1 = two's-complement compare, 0 = unsigned
//            InValid/InReady   - input handshake
//            AEB/AGB/ALB       - registered compare flags
//            OutValid/OutReady - output handshake
//            CntClr            - synchronous clear of all counters
//            CntEQ/CntGT/CntLT - saturating result counters
// Revision : 1.0 - initial release
// ============================================================================
module zjh_cmp_pipe #(
   parameter int WIDTH     = 8,
   parameter int GRAY_IN   = 0,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [WIDTH-1:0]     DataA,
   input  logic [WIDTH-1:0]     DataB,
   input  logic                 SignedMode,
   input  logic                 InValid,
   output logic                 InReady,
   output logic                 AEB,
   output logic                 AGB,
   output logic                 ALB,
   output logic                 OutValid,
   input  logic                 OutReady,
   input  logic                 CntClr,
   output logic [CNT_WIDTH-1:0] CntEQ,
   output logic [CNT_WIDTH-1:0] CntGT,
   output logic [CNT_WIDTH-1:0] CntLT
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   // ------------------------------------------------------------------
   // Operand conversion (combinational, ahead of the stage-1 register)
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] a_bin;
   logic [WIDTH-1:0] b_bin;

   generate
      if (GRAY_IN != 0) begin : g_gray
         // Binary bit i is the XOR of all Gray bits from the MSB down to i.
         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign a_bin[i] = ^(DataA >> i);
            assign b_bin[i] = ^(DataB >> i);
         end
      end else begin : g_pass
         assign a_bin = DataA;
         assign b_bin = DataB;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Handshake / advance control
   // ------------------------------------------------------------------
   logic s1_valid;
   logic s2_adv;
   logic s1_adv;
   logic out_hs;

   assign s2_adv  = !OutValid || OutReady;
   // Stage 1 may load whenever it is empty, even if stage 2 is stalled.
   assign s1_adv  = !s1_valid || s2_adv;
   assign InReady = s1_adv;
   assign out_hs  = OutValid && OutReady;

   // ------------------------------------------------------------------
   // Stage 1: converted operands and their compare mode
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic             s1_signed;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1_valid  <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_signed <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= InValid;
         if (InValid) begin
            s1_a      <= a_bin;
            s1_b      <= b_bin;
            s1_signed <= SignedMode;
         end
      end
   end

   // ------------------------------------------------------------------
   // Compare: inverting the sign bit maps two's-complement ordering onto
   // unsigned ordering, so one unsigned comparator serves both modes.
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] cmp_a;
   logic [WIDTH-1:0] cmp_b;
   logic             eq_next;
   logic             gt_next;
   logic             lt_next;

   assign cmp_a   = s1_a ^ {s1_signed, {(WIDTH-1){1'b0}}};
   assign cmp_b   = s1_b ^ {s1_signed, {(WIDTH-1){1'b0}}};
   assign eq_next = (cmp_a == cmp_b);
   assign gt_next = (cmp_a > cmp_b);
   assign lt_next = !eq_next && !gt_next;

   // ------------------------------------------------------------------
   // Stage 2: registered flags. Flags only load with a valid result, so
   // they hold their last value while OutValid is low.
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         OutValid <= 1'b0;
         AEB      <= 1'b0;
         AGB      <= 1'b0;
         ALB      <= 1'b0;
      end else if (s2_adv) begin
         OutValid <= s1_valid;
         if (s1_valid) begin
            AEB <= eq_next;
            AGB <= gt_next;
            ALB <= lt_next;
         end
      end
   end

   // ------------------------------------------------------------------
   // Saturating event counters; clear takes priority over a handshake.
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         CntEQ <= '0;
         CntGT <= '0;
         CntLT <= '0;
      end else if (CntClr) begin
         CntEQ <= '0;
         CntGT <= '0;
         CntLT <= '0;
      end else if (out_hs) begin
         if (AEB && (CntEQ != CNT_MAX)) CntEQ <= CntEQ + CNT_ONE;
         if (AGB && (CntGT != CNT_MAX)) CntGT <= CntGT + CNT_ONE;
         if (ALB && (CntLT != CNT_MAX)) CntLT <= CntLT + CNT_ONE;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_zjh_cmp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_zjh_cmp_pipe
// Purpose  : Scoreboard bench for zjh_cmp_pipe. Three instances share one
//            stimulus stream: u_bin (binary, 16-bit counters), u_gray
//            (Gray-coded operands) and u_sat (2-bit counters). Each issued
//            vector carries hand-computed flags for the binary and Gray
//            interpretations; a monitor pops them at each output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zjh_cmp_pipe;

   localparam logic [2:0] C_GT = 3'b100;   // {AGB,AEB,ALB}
   localparam logic [2:0] C_EQ = 3'b010;
   localparam logic [2:0] C_LT = 3'b001;

   logic       clk;
   logic       rst;
   logic [7:0] data_a;
   logic [7:0] data_b;
   logic       signed_mode;
   logic       in_valid;
   logic       out_ready;
   logic       cnt_clr;

   logic        rdy0, aeb0, agb0, alb0, ov0;
   logic [15:0] eq0, gt0, lt0;
   logic        rdy1, aeb1, agb1, alb1, ov1;
   logic [15:0] eq1, gt1, lt1;
   logic        rdy2, aeb2, agb2, alb2, ov2;
   logic [1:0]  eq2, gt2, lt2;

   zjh_cmp_pipe #(.WIDTH(8), .GRAY_IN(0), .CNT_WIDTH(16)) u_bin (
      .CLK(clk), .RST(rst), .DataA(data_a), .DataB(data_b),
      .SignedMode(signed_mode), .InValid(in_valid), .InReady(rdy0),
      .AEB(aeb0), .AGB(agb0), .ALB(alb0), .OutValid(ov0),
      .OutReady(out_ready), .CntClr(cnt_clr),
      .CntEQ(eq0), .CntGT(gt0), .CntLT(lt0));

   zjh_cmp_pipe #(.WIDTH(8), .GRAY_IN(1), .CNT_WIDTH(16)) u_gray (
      .CLK(clk), .RST(rst), .DataA(data_a), .DataB(data_b),
      .SignedMode(signed_mode), .InValid(in_valid), .InReady(rdy1),
      .AEB(aeb1), .AGB(agb1), .ALB(alb1), .OutValid(ov1),
      .OutReady(out_ready), .CntClr(cnt_clr),
      .CntEQ(eq1), .CntGT(gt1), .CntLT(lt1));

   zjh_cmp_pipe #(.WIDTH(8), .GRAY_IN(0), .CNT_WIDTH(2)) u_sat (
      .CLK(clk), .RST(rst), .DataA(data_a), .DataB(data_b),
      .SignedMode(signed_mode), .InValid(in_valid), .InReady(rdy2),
      .AEB(aeb2), .AGB(agb2), .ALB(alb2), .OutValid(ov2),
      .OutReady(out_ready), .CntClr(cnt_clr),
      .CntEQ(eq2), .CntGT(gt2), .CntLT(lt2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [5:0] sb[$];          // {binary flags, gray flags}
   logic       stall_prev = 1'b0;
   logic [2:0] stall_flags = 3'b000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at a negedge; returns at the negedge following acceptance.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [2:0] e_bin, input logic [2:0] e_gray);
      int n = 0;
      data_a      = a;
      data_b      = b;
      signed_mode = s;
      in_valid    = 1'b1;
      #1;
      while (!rdy0 && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!rdy0) begin
         check("send_timeout", 32'(rdy0), 32'd1);
      end else begin
         sb.push_back({e_bin, e_gray});
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   // Monitor: pops an expectation at every output handshake and checks
   // that a stalled output holds steady.
   always @(negedge clk) begin
      logic [5:0] e;
      #2;
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_valid", 32'(ov0), 32'd1);
            check("stall_flags", 32'({agb0, aeb0, alb0}), 32'(stall_flags));
         end
         if (ov0 && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_out", 32'(ov0), 32'd0);
            end else begin
               e = sb.pop_front();
               check("flags_bin",  32'({agb0, aeb0, alb0}), 32'(e[5:3]));
               check("valid_gray", 32'(ov1), 32'd1);
               check("flags_gray", 32'({agb1, aeb1, alb1}), 32'(e[2:0]));
            end
         end
         stall_prev  = ov0 && !out_ready;
         stall_flags = {agb0, aeb0, alb0};
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      data_a      = '0;
      data_b      = '0;
      signed_mode = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      cnt_clr     = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_outvalid", 32'(ov0), 32'd0);
      check("rst_flags", 32'({agb0, aeb0, alb0}), 32'd0);
      check("rst_cnt", 32'({eq0, gt0, lt0}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("inready_after_rst", 32'(rdy0), 32'd1);
      @(negedge clk);

      // 1: single unsigned transaction, latency, counter
      send(8'h80, 8'h7F, 1'b0, C_GT, C_GT);
      idle();
      #1;
      check("lat_cycle1", 32'(ov0), 32'd0);
      @(negedge clk);
      #1;
      check("lat_cycle2", 32'(ov0), 32'd1);
      check("t1_agb", 32'(agb0), 32'd1);
      @(negedge clk);
      #1;
      check("t1_cnt_gt", 32'(gt0), 32'd1);
      drain();

      // 2: signed compare, then equal operands
      send(8'h80, 8'h7F, 1'b1, C_LT, C_LT);
      send(8'hFF, 8'hFF, 1'b1, C_EQ, C_EQ);
      idle();
      drain();
      @(negedge clk);
      check("t2_cnt_lt", 32'(lt0), 32'd1);
      check("t2_cnt_eq", 32'(eq0), 32'd1);

      // 3: Gray operands 0b11 (=2) vs 0b10 (=3)
      send(8'h03, 8'h02, 1'b0, C_GT, C_LT);
      idle();
      drain();

      // 4: back-to-back stream under backpressure
      @(negedge clk);
      fork
         begin
            send(8'h10, 8'h20, 1'b0, C_LT, C_LT);
            send(8'h20, 8'h10, 1'b0, C_GT, C_GT);
            send(8'h55, 8'h55, 1'b0, C_EQ, C_EQ);
            send(8'h01, 8'h00, 1'b0, C_GT, C_GT);
            idle();
         end
         begin
            out_ready = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            #2;
            check("t4_inready_low", 32'(rdy0), 32'd0);
            repeat (3) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain();
      @(negedge clk);
      check("t4_cnt_gt", 32'(gt0), 32'd4);
      check("t4_cnt_lt", 32'(lt0), 32'd2);
      check("t4_cnt_eq", 32'(eq0), 32'd2);

      // 5: clear, then saturate LT on the 2-bit counters
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      #1;
      check("t5_clr_lt", 32'(lt0), 32'd0);
      @(negedge clk);
      for (int i = 0; i < 5; i++) send(8'h00, 8'h01, 1'b0, C_LT, C_LT);
      idle();
      drain();
      @(negedge clk);
      check("t5_sat_lt", 32'(lt2), 32'd3);
      check("t5_sat_gt", 32'(gt2), 32'd0);
      check("t5_wide_lt", 32'(lt0), 32'd5);

      // Clear coinciding with a handshake: clear wins
      send(8'h55, 8'h55, 1'b0, C_EQ, C_EQ);
      idle();
      @(negedge clk);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      #1;
      check("t5_clrhs_bin", 32'({eq0, gt0, lt0}), 32'd0);
      check("t5_clrhs_sat", 32'({eq2, gt2, lt2}), 32'd0);
      drain();

      // 6: asynchronous reset with two transactions in flight
      @(negedge clk);
      send(8'h20, 8'h10, 1'b0, C_GT, C_GT);
      send(8'h20, 8'h10, 1'b0, C_GT, C_GT);
      send(8'h20, 8'h10, 1'b0, C_GT, C_GT);
      out_ready = 1'b0;
      idle();
      #1;
      check("t6_cnt_before", 32'(gt0), 32'd1);
      check("t6_inflight_valid", 32'(ov0), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_ov_bin", 32'(ov0), 32'd0);
      check("t6_ov_gray", 32'(ov1), 32'd0);
      check("t6_cnt_zero", 32'({eq0, gt0, lt0}), 32'd0);
      check("t6_pending", 32'(sb.size()), 32'd2);
      sb.delete();
      repeat (2) @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         check("t6_no_stale", 32'(ov0), 32'd0);
         check("t6_inready", 32'(rdy0), 32'd1);
      end
      check("t6_cnt_after", 32'({eq0, gt0, lt0}), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
